// File: rtl/iob_wr_aligner.sv
// iob_wr_aligner: splits byte-addressed right-justified writes into word-aligned strobed beats
module iob_wr_aligner #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [1:0]        s_size,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb
);
  localparam int NB = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  typedef enum logic [1:0] {IDLE, LO, SEND} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d, hold_addr_q, hold_addr_d, base;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d, hold_wdata_q, hold_wdata_d, data_m;
  logic [NB-1:0] m_wstrb_q, m_wstrb_d, hold_wstrb_q, hold_wstrb_d, mask;
  logic [2*NB-1:0] ext_strb;
  logic [2*DATA_W-1:0] ext_data;
  logic [OFF_W-1:0] off;
  logic [1:0] sz;
  logic split, accept;
  // Clamp the size, build the byte mask and shift strobe/data into their lanes across two words
  always_comb begin
    off = s_addr[OFF_W-1:0];
    sz = (32'(s_size) > OFF_W) ? 2'(OFF_W) : s_size;
    mask = '0;
    data_m = '0;
    for (int i = 0; i < NB; i++) begin
      mask[i] = i < (32'd1 << sz);
      data_m[8*i+:8] = mask[i] ? s_wdata[8*i+:8] : 8'h00;
    end
    ext_strb = {{NB{1'b0}}, mask} << off;
    ext_data = {{DATA_W{1'b0}}, data_m} << {off, 3'b000};
    split = |ext_strb[2*NB-1:NB];
    base = {s_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end
  // Handshake, next state and beat loading; the second beat of a split waits in the hold registers
  always_comb begin
    s_ready = (state_q == IDLE) || (state_q == SEND && m_ready);
    m_valid = state_q != IDLE;
    accept = s_valid && s_ready;
    state_d = state_q;
    m_addr_d = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    hold_addr_d = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    hold_wstrb_d = hold_wstrb_q;
    if (accept) begin
      state_d = split ? LO : SEND;
      m_addr_d = base;
      m_wdata_d = ext_data[DATA_W-1:0];
      m_wstrb_d = ext_strb[NB-1:0];
      hold_addr_d = base + ADDR_W'(NB);
      hold_wdata_d = ext_data[2*DATA_W-1:DATA_W];
      hold_wstrb_d = ext_strb[2*NB-1:NB];
    end else if (state_q == LO && m_ready) begin
      state_d = SEND;
      m_addr_d = hold_addr_q;
      m_wdata_d = hold_wdata_q;
      m_wstrb_d = hold_wstrb_q;
    end else if (state_q == SEND && m_ready) begin
      state_d = IDLE;
    end
  end
  // State and beat registers, cleared asynchronously
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      m_addr_q <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      hold_addr_q <= '0;
      hold_wdata_q <= '0;
      hold_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      hold_addr_q <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      hold_wstrb_q <= hold_wstrb_d;
    end
  end
  assign m_addr = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
endmodule

// File: tb/tb_iob_wr_aligner.sv
// tb_iob_wr_aligner: directed checks of beat alignment, splitting, backpressure and reset
module tb_iob_wr_aligner;
  logic clk = 0, arst_n = 0, s_valid = 0, s_ready, m_valid, m_ready = 1;
  logic [31:0] s_addr = 0, s_wdata = 0, m_addr, m_wdata;
  logic [1:0] s_size = 0;
  logic [3:0] m_wstrb;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  iob_wr_aligner #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_size(s_size), .s_wdata(s_wdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic req(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    s_valid = 1;
    s_addr = a;
    s_size = sz;
    s_wdata = d;
  endtask
  task automatic beat(input string tag, input logic [31:0] a, input logic [3:0] st, input logic [31:0] d);
    chk({tag, " valid"}, 64'(m_valid), 64'd1);
    chk({tag, " addr"}, 64'(m_addr), 64'(a));
    chk({tag, " wstrb"}, 64'(m_wstrb), 64'(st));
    chk({tag, " wdata"}, 64'(m_wdata), 64'(d));
  endtask
  initial begin
    #2;
    chk("rst valid", 64'(m_valid), 64'd0);
    chk("rst addr", 64'(m_addr), 64'd0);
    chk("rst wdata", 64'(m_wdata), 64'd0);
    chk("rst wstrb", 64'(m_wstrb), 64'd0);
    chk("rst s_ready", 64'(s_ready), 64'd1);
    #6 arst_n = 1;
    tick();
    for (int o = 0; o < 4; o++) begin
      req(32'h20 + 32'(o), 2'd0, 32'h5A);
      tick();
      beat($sformatf("byte%0d", o), 32'h20, 4'b0001 << o, 32'h5A << (8 * o));
    end
    s_valid = 0;
    tick();
    chk("byte idle", 64'(m_valid), 64'd0);
    req(32'h13, 2'd1, 32'hFFFF1234);
    tick();
    s_valid = 0;
    beat("half b0", 32'h10, 4'b1000, 32'h34000000);
    chk("half lo s_ready", 64'(s_ready), 64'd0);
    tick();
    beat("half b1", 32'h14, 4'b0001, 32'h00000012);
    chk("half send s_ready", 64'(s_ready), 64'd1);
    tick();
    chk("half idle", 64'(m_valid), 64'd0);
    m_ready = 0;
    req(32'h102, 2'd2, 32'hAABBCCDD);
    tick();
    s_valid = 0;
    beat("bp b0", 32'h100, 4'b1100, 32'hCCDD0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      beat($sformatf("bp hold%0d", i), 32'h100, 4'b1100, 32'hCCDD0000);
    end
    m_ready = 1;
    tick();
    beat("bp b1", 32'h104, 4'b0011, 32'h0000AABB);
    tick();
    chk("bp idle", 64'(m_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      req(32'(4 * i), 2'd2, 32'h11111111 * 32'(i + 1));
      #1 chk($sformatf("b2b s_ready%0d", i), 64'(s_ready), 64'd1);
      tick();
      beat($sformatf("b2b%0d", i), 32'(4 * i), 4'b1111, 32'h11111111 * 32'(i + 1));
    end
    s_valid = 0;
    tick();
    chk("b2b idle", 64'(m_valid), 64'd0);
    req(32'h30, 2'd3, 32'h12345678);
    tick();
    s_valid = 0;
    beat("clamp", 32'h30, 4'b1111, 32'h12345678);
    tick();
    req(32'hFFFFFFFE, 2'd2, 32'h01020304);
    tick();
    s_valid = 0;
    beat("wrap b0", 32'hFFFFFFFC, 4'b1100, 32'h03040000);
    tick();
    beat("wrap b1", 32'h0, 4'b0011, 32'h00000102);
    tick();
    req(32'h13, 2'd1, 32'h0000BEEF);
    tick();
    s_valid = 0;
    beat("mid b0", 32'h10, 4'b1000, 32'hEF000000);
    #1 arst_n = 0;
    #1;
    chk("mid rst valid", 64'(m_valid), 64'd0);
    chk("mid rst addr", 64'(m_addr), 64'd0);
    chk("mid rst wdata", 64'(m_wdata), 64'd0);
    chk("mid rst wstrb", 64'(m_wstrb), 64'd0);
    chk("mid rst s_ready", 64'(s_ready), 64'd1);
    #3 arst_n = 1;
    tick();
    chk("mid no b1", 64'(m_valid), 64'd0);
    tick();
    chk("mid no b1 later", 64'(m_valid), 64'd0);
    req(32'h40, 2'd2, 32'hDEADBEEF);
    tick();
    s_valid = 0;
    beat("post rst", 32'h40, 4'b1111, 32'hDEADBEEF);
    tick();
    chk("post rst idle", 64'(m_valid), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/iob_wr_aligner.md
# iob_wr_aligner

Write-request aligner: converts a byte-addressed, size-qualified, right-justified write (address offset + size in) into word-aligned native-bus beats carrying shifted data and a byte write strobe (wstrb out). It is the encoding direction of the strobe-to-offset decode used on the memory side. Writes that cross a word boundary are split into two beats. It sits between a CPU/DMA write master and any iob native-bus slave.

## Interface
- DATA_W, 32, bus data width in bits; 32 or 64; NB = DATA_W/8 bytes, OFF_W = $clog2(NB)
- ADDR_W, 32, byte address width
- clk  in  1  clock; all logic on rising edge
- arst_n  in  1  asynchronous reset, active-low
- s_valid  in  1  write request valid
- s_ready  out  1  request accepted when s_valid && s_ready
- s_addr  in  ADDR_W  byte address, any alignment
- s_size  in  2  log2 of byte count: 0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
- s_wdata  in  DATA_W  write data, right-justified in LSBs
- m_valid  out  1  output beat valid
- m_ready  in  1  beat consumed when m_valid && m_ready
- m_addr  out  ADDR_W  word-aligned address, low OFF_W bits always 0
- m_wdata  out  DATA_W  byte-lane-aligned data
- m_wstrb  out  NB  byte write strobe

## Operation
- Size clamp: s_size > OFF_W is treated as OFF_W (full word).
- On accept: off = s_addr[OFF_W-1:0]; nbytes = 1 << size; mask = (1 << nbytes) - 1 (NB bits); data bytes above nbytes forced to 0.
- Extended strobe (2*NB bits) = mask << off; extended data (2*DATA_W bits) = masked data << (8*off).
- Low half gives beat 0 at base = {s_addr[ADDR_W-1:OFF_W], OFF_W'b0}. High half gives beat 1 at base + NB, modulo 2^ADDR_W (wraps to 0).
- split = |(high half of extended strobe). Bytes outside the strobe drive 0 on m_wdata.
- State machine (registered):
  - IDLE: m_valid=0, s_ready=1. On accept, load beat 0 and go to LO if split, otherwise SEND.
  - LO: m_valid=1 with beat 0; beat 1 held internally; s_ready=0. On m_ready, load beat 1 and go to SEND.
  - SEND: m_valid=1; s_ready=m_ready. On m_ready with s_valid, load the new request and go to LO or SEND. On m_ready without s_valid, go to IDLE.
- m_addr, m_wdata and m_wstrb hold stable while m_valid && !m_ready.
- A request is never dropped or reordered; beat 0 always precedes beat 1.

## Timing
- Reset (arst_n=0, asynchronous): state=IDLE, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, held beat cleared. s_ready=1 because it is combinational from IDLE.
- Latency: m_valid rises 1 cycle after the accepting edge.
- Throughput with m_ready=1: one non-split request per cycle, back-to-back; a split request takes 2 cycles, and s_ready=0 during its LO cycle.
- s_ready is combinational on m_ready in SEND only; there is no combinational path from s_* to m_*.
- Reset asserted mid-split discards beat 1; after release the block is in IDLE with no pending beat.
- Simultaneous m_ready and new accept in SEND: the new beat replaces the old one on the same edge with no bubble.

## Test plan
- Byte writes, DATA_W=32, m_ready=1: s_addr=0x21, size 0, s_wdata=0x5A -> one beat: m_addr=0x20, wstrb=0010, m_wdata=0x00005A00. Repeat for offsets 0..3 (wstrb 0001/0010/0100/1000).
- Half split: s_addr=0x13, size 1, s_wdata=0xFFFF1234 -> beat0 m_addr=0x10, wstrb=1000, m_wdata=0x34000000; beat1 m_addr=0x14, wstrb=0001, m_wdata=0x00000012. s_ready=0 during beat 0.
- Word split with backpressure: s_addr=0x102, size 2, s_wdata=0xAABBCCDD, m_ready low for 3 cycles -> beat0 held stable (0x100, 1100, 0xCCDD0000), then beat1 (0x104, 0011, 0x0000AABB).
- Back-to-back: aligned words at 0x0, 0x4, 0x8 on consecutive cycles, m_ready=1 -> three beats on consecutive cycles with wstrb=1111 and no bubble.
- Address wrap: s_addr=0xFFFFFFFE, size 2 -> beat0 m_addr=0xFFFFFFFC, wstrb=1100; beat1 m_addr=0x00000000, wstrb=0011.
- Reset mid-split: assert arst_n=0 while in LO -> m_valid=0 and outputs 0 immediately; after release, beat 1 is never emitted and the next request behaves normally.
